// File: rtl/uart_tx_now_if.sv
// Byte-producer to UART transmitter connection: request strobe, data byte,
// serial line and status/debug outputs.
interface uart_tx_now_if;
    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Active;
    logic       o_Tx_Serial;
    logic       o_Tx_Done;
    logic [2:0] o_SM_Main;
    logic       uart_clk_edge;

    modport master (
        output i_Tx_DV, i_Tx_Byte,
        input  o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_SM_Main, uart_clk_edge
    );

    modport slave (
        input  i_Tx_DV, i_Tx_Byte,
        output o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_SM_Main, uart_clk_edge
    );
endinterface

// File: rtl/uart_tx_now.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, then a
// one-cycle cleanup state that carries the done pulse.
module uart_tx_now #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic         i_Clock,
    input  logic         i_Reset,
    uart_tx_now_if.slave tx
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    idx_r, idx_s;
    logic [7:0]    latch_r, latch_s;
    logic          serial_r, serial_s;
    logic          active_r, active_s;
    logic          done_r, done_s;
    logic          last_s;

    assign last_s = (cnt_r == LAST_CNT);

    // Next-state, bit counter, bit index and data latch.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        latch_s = latch_r;
        case (state_r)
            IDLE: begin
                cnt_s = '0;
                idx_s = 3'd0;
                if (tx.i_Tx_DV) begin
                    latch_s = tx.i_Tx_Byte;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (last_s) begin
                    cnt_s   = '0;
                    state_s = DATA;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            DATA: begin
                if (last_s) begin
                    cnt_s = '0;
                    if (idx_r < 3'd7) begin
                        idx_s = idx_r + 3'd1;
                    end else begin
                        idx_s   = 3'd0;
                        state_s = STOP;
                    end
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            STOP: begin
                if (last_s) begin
                    cnt_s   = '0;
                    state_s = CLEANUP;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            CLEANUP: begin
                cnt_s   = '0;
                idx_s   = 3'd0;
                state_s = IDLE;
            end
            default: begin
                cnt_s   = '0;
                idx_s   = 3'd0;
                state_s = IDLE;
            end
        endcase
    end

    // Line outputs are decoded from the next state so each bit appears on the
    // same edge that starts its bit period, with no extra cycle of delay.
    always_comb begin
        serial_s = 1'b1;
        active_s = 1'b0;
        done_s   = 1'b0;
        case (state_s)
            START: begin
                serial_s = 1'b0;
                active_s = 1'b1;
            end
            DATA: begin
                serial_s = latch_s[idx_s];
                active_s = 1'b1;
            end
            STOP: begin
                serial_s = 1'b1;
                active_s = 1'b1;
            end
            CLEANUP: begin
                done_s = 1'b1;
            end
            default: begin
                serial_s = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            idx_r    <= 3'd0;
            latch_r  <= 8'd0;
            serial_r <= 1'b1;
            active_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            idx_r    <= idx_s;
            latch_r  <= latch_s;
            serial_r <= serial_s;
            active_r <= active_s;
            done_r   <= done_s;
        end
    end

    assign tx.o_Tx_Serial   = serial_r;
    assign tx.o_Tx_Active   = active_r;
    assign tx.o_Tx_Done     = done_r;
    assign tx.o_SM_Main     = state_r;
    assign tx.uart_clk_edge = last_s &&
                              ((state_r == START) || (state_r == DATA) || (state_r == STOP));
endmodule

// File: tb/tb_uart_tx_now.sv
// Self-checking bench for uart_tx_now: stimulus pushes expected frames into a
// scoreboard queue; a negedge monitor decodes the line and compares.
module tb_uart_tx_now;
    localparam int CPB = 87;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_tx_now_if ifc();

    uart_tx_now #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .tx      (ifc.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int sent = 0;
    int frames_ok = 0;
    int aborted = 0;
    logic [9:0] exp_q[$];
    int starts[$];

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame bit k: 0 = start (low), 1..8 = data LSB first, 9 = stop (high).
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (ifc.o_Tx_Done === 1'b1) done_cnt++;

    // Monitor: decodes each frame off the line and checks it against the queue.
    logic [9:0] cur;
    bit in_frame = 0;
    int pos, bad, edges, k, exp_sm;
    bit exp_edge;
    always @(negedge clk) begin
        if (rst) begin
            if (in_frame) aborted++;
            in_frame = 0;
        end else begin
            if (!in_frame && ifc.o_Tx_Serial === 1'b0) begin
                chk("start_expected", exp_q.size() > 0, 1, 0);
                cur = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
                in_frame = 1;
                pos = 0;
                bad = 0;
                edges = 0;
                starts.push_back(cyc);
            end
            if (in_frame) begin
                if (pos < 10 * CPB) begin
                    k = pos / CPB;
                    exp_sm = (k == 0) ? 1 : ((k == 9) ? 3 : 2);
                    exp_edge = ((pos % CPB) == CPB - 1);
                    if (ifc.o_Tx_Serial !== cur[k] || ifc.o_Tx_Active !== 1'b1 ||
                        ifc.o_Tx_Done !== 1'b0 || ifc.o_SM_Main !== 3'(exp_sm) ||
                        ifc.uart_clk_edge !== exp_edge) bad++;
                    if (ifc.uart_clk_edge === 1'b1) edges++;
                end else if (pos == 10 * CPB) begin
                    chk("done_at_10bits", ifc.o_Tx_Done === 1'b1 && ifc.o_Tx_Active === 1'b0 &&
                        ifc.o_Tx_Serial === 1'b1 && ifc.o_SM_Main === 3'd4,
                        int'(ifc.o_SM_Main), 4);
                end else begin
                    chk("done_clears", ifc.o_Tx_Done === 1'b0 && ifc.o_SM_Main === 3'd0 &&
                        ifc.o_Tx_Active === 1'b0, int'(ifc.o_SM_Main), 0);
                    chk("frame_cycles", bad == 0, bad, 0);
                    chk("clk_edge_count", edges == 10, edges, 10);
                    frames_ok++;
                    in_frame = 0;
                end
                pos++;
            end
        end
    end

    // Present a byte at #1 after a posedge while the DUT is idle; hold DV for
    // 'hold' edges, optionally replacing the byte after the first edge.
    task automatic send(input logic [7:0] b, input int hold, input bit change, input logic [7:0] alt);
        ifc.i_Tx_DV   = 1'b1;
        ifc.i_Tx_Byte = b;
        exp_q.push_back(frame_of(b));
        sent++;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (change) ifc.i_Tx_Byte = alt;
        end
        ifc.i_Tx_DV = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (ifc.o_Tx_Done !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, ifc.o_Tx_Done === 1'b1, n, 10 * CPB);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, ebad, ecnt, hold, gap;
        logic [7:0] b;
        bit change;

        ifc.i_Tx_DV   = 1'b0;
        ifc.i_Tx_Byte = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset: line high, nothing active, no strobes.
        ebad = 0;
        ecnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (ifc.o_Tx_Serial !== 1'b1 || ifc.o_Tx_Active !== 1'b0 ||
                ifc.o_Tx_Done !== 1'b0 || ifc.o_SM_Main !== 3'd0) ebad++;
            if (ifc.uart_clk_edge !== 1'b0) ecnt++;
        end
        chk("idle_outputs", ebad == 0, ebad, 0);
        chk("idle_no_clk_edge", ecnt == 0, ecnt, 0);

        // 0x61 with DV held 5 cycles: exactly one frame.
        d0 = done_cnt;
        send(8'h61, 5, 1'b0, 8'h00);
        wait_done("done_0x61");
        repeat (20) @(posedge clk);
        #1 chk("one_done_0x61", done_cnt - d0 == 1, done_cnt - d0, 1);
        chk("no_extra_frame", exp_q.size() == 0, exp_q.size(), 0);

        // 0x61 with byte changed to 0xFF after acceptance.
        send(8'h61, 1, 1'b1, 8'hFF);
        wait_done("done_0x61_chg");
        @(posedge clk); #1;

        // Back-to-back 0x00 then 0xFF, DV raised as soon as done pulses.
        send(8'h00, 1, 1'b0, 8'h00);
        wait_done("done_b2b_a");
        send(8'hFF, 2, 1'b0, 8'h00);
        wait_done("done_b2b_b");
        @(posedge clk); #1;
        chk("b2b_spacing", starts.size() >= 2 && starts[$] - starts[$-1] == 10 * CPB + 2,
            starts[$] - starts[$-1], 10 * CPB + 2);

        // Reset about 400 cycles into a frame.
        b = 8'($urandom_range(0, 255));
        send(b, 1, 1'b0, 8'h00);
        repeat (400) @(posedge clk);
        d0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        chk("rst_serial", ifc.o_Tx_Serial === 1'b1, int'(ifc.o_Tx_Serial), 1);
        chk("rst_active", ifc.o_Tx_Active === 1'b0, int'(ifc.o_Tx_Active), 0);
        chk("rst_sm", ifc.o_SM_Main === 3'd0, int'(ifc.o_SM_Main), 0);
        chk("rst_clk_edge", ifc.uart_clk_edge === 1'b0, int'(ifc.uart_clk_edge), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (1000) @(posedge clk);
        #1 chk("rst_no_done", done_cnt == d0, done_cnt - d0, 0);
        chk("rst_aborted", aborted == 1, aborted, 1);

        send(8'hA5, 1, 1'b0, 8'h00);
        wait_done("done_0xA5");
        @(posedge clk); #1;

        // Randomised bytes, DV lengths, post-accept byte changes and gaps.
        for (int i = 0; i < 12; i++) begin
            b      = 8'($urandom_range(0, 255));
            hold   = $urandom_range(1, 5);
            change = 1'($urandom_range(0, 1));
            send(b, hold, change, ~b);
            wait_done("done_rand");
            gap = $urandom_range(1, 15);
            repeat (gap) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size() == 0, exp_q.size(), 0);
        chk("frames_completed", frames_ok == sent - 1, frames_ok, sent - 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_now.md
# uart_tx_now

Byte-wide UART transmitter: accepts a parallel byte on a one-cycle-or-longer valid strobe and serialises it as 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) on a single line. It sits between a byte producer (host logic, FIFO) and the board TX pin. It exposes busy/done status, its state-machine encoding and a bit-boundary strobe for debug and monitoring.

## Interface
- CLKS_PER_BIT, default 87: clock cycles per bit period, computed as clock frequency / baud rate (87 gives 115200 baud at 10 MHz; 868 gives 115200 baud at 100 MHz). Legal range is 2 or more.
- i_Clock  input  1  system clock, rising-edge.
- i_Reset  input  1  reset, asynchronous, active-high.
- i_Tx_DV  input  1  transmit request; sampled only in IDLE.
- i_Tx_Byte  input  8  byte to send; captured in the cycle i_Tx_DV is accepted.
- o_Tx_Active  output  1  high while a frame (start, data, stop) is on the line.
- o_Tx_Serial  output  1  serial line; idles high.
- o_Tx_Done  output  1  one-cycle pulse at frame completion.
- o_SM_Main  output  3  current state encoding.
- uart_clk_edge  output  1  one-cycle strobe on the last cycle of each bit period.

## Operation
- States and encodings: IDLE=0, START=1, DATA=2, STOP=3, CLEANUP=4. Codes 5–7 are unreachable; if entered, go to IDLE on the next edge.
- Registered internals:
  - Clock counter, width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1 within each bit.
  - 3-bit bit index.
  - 8-bit data latch.
- IDLE:
  - o_Tx_Serial=1, o_Tx_Active=0, counter and index cleared.
  - If i_Tx_DV=1: latch i_Tx_Byte, set o_Tx_Serial=0 and o_Tx_Active=1, go to START.
- START: hold serial 0. When counter reaches CLKS_PER_BIT-1, clear counter and go to DATA.
- DATA:
  - Drive latch[index].
  - At counter CLKS_PER_BIT-1, clear counter.
  - If index<7, increment index and stay in DATA.
  - If index==7, clear index and go to STOP.
- STOP: drive 1. At counter CLKS_PER_BIT-1, go to CLEANUP, set o_Tx_Done=1 and o_Tx_Active=0.
- CLEANUP: lasts one cycle. o_Tx_Done returns to 0 on exit; go to IDLE.
- i_Tx_DV is ignored outside IDLE. i_Tx_Byte changes after acceptance have no effect on the frame in flight.
- uart_clk_edge is a combinational decode: (state is START, DATA or STOP) AND counter==CLKS_PER_BIT-1. It is 0 otherwise.
- Reset, asynchronous, takes effect at any time including mid-frame:
  - state=IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0.
  - Counter=0, index=0, latch=0, o_SM_Main=0, uart_clk_edge=0.
  - The partial frame is abandoned.

## Timing
- Let E0 be the edge that samples i_Tx_DV=1 in IDLE.
- At E0: o_Tx_Serial falls to 0 and o_Tx_Active rises. There is zero cycles of added latency beyond registration.
- Bit k (0=start, 1..8=data, 9=stop) occupies the cycles from edge E0+k·CLKS_PER_BIT to edge E0+(k+1)·CLKS_PER_BIT.
- Edge E0+10·CLKS_PER_BIT: o_Tx_Done=1, o_Tx_Active=0, o_Tx_Serial stays 1, state=CLEANUP.
- Edge E0+10·CLKS_PER_BIT+1: o_Tx_Done=0, state=IDLE.
- The earliest next acceptance edge is E0+10·CLKS_PER_BIT+2. Minimum frame-to-frame spacing is 10·CLKS_PER_BIT+2 cycles.
- uart_clk_edge pulses exactly 10 times per frame, each one cycle before a bit transition.
- All outputs except uart_clk_edge are registered and glitch-free.

## Test plan
- Reset release, no DV for 100 cycles:
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_SM_Main=0, no uart_clk_edge pulses.
- CLKS_PER_BIT=87, i_Tx_Byte=0x61, i_Tx_DV held high 5 cycles:
  - Line shows 0,1,0,0,0,0,1,1,0,1, each bit exactly 87 cycles.
  - o_Tx_Done pulses once, 870 cycles after E0.
  - Only one frame is sent despite the multi-cycle DV.
- Same frame with i_Tx_Byte changed to 0xFF one cycle after E0: data bits remain those of 0x61.
- Back-to-back bytes 0x00 then 0xFF, DV re-asserted as soon as o_Tx_Done pulses:
  - Second start bit begins 872 cycles after the first.
  - Line sequence is correct for both bytes.
- Check o_SM_Main sequence 0→1→2→3→4→0 and count exactly 10 uart_clk_edge pulses per frame.
- Assert i_Reset mid-DATA (≈400 cycles into a frame):
  - Line goes 1 immediately, o_Tx_Active=0, o_SM_Main=0, no o_Tx_Done pulse.
  - A subsequent byte 0xA5 transmits correctly.
